axi_lite_req_arbiter: RTL and testbench

Two-requester scheduler that shares one AXI4-Lite master port into the px2_game register slave (4 × 32-bit registers at offsets 0x0–0xC). Each requester issues single-beat read or write commands over a simple req/ack interface. The block round-robin arbitrates between requesters and sequences the AW/W/B and AR/R channels. A watchdog recovers from a hung slave.

---
 rtl/axi_lite_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_lite_req_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin scheduler that lets two req/ack requesters share one AXI4-Lite
// master port, with a watchdog that forces completion when the slave hangs.
module axi_lite_req_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic              ACLK,
    input  logic              ARESET,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_wstrb,
    output logic              r0_ack,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_wstrb,
    output logic              r1_ack,

    output logic [31:0]       rdata,
    output logic [1:0]        resp,
    output logic              ack_id,
    output logic              busy,
    output logic              timeout_err,
    output logic [2:0]        dbg_state,

    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    // A transfer happens on a rising edge where valid && ready are both high;
    // valids depend only on registered state, never on the slave's ready.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    // The count starts in the first cycle after the grant, so DONE lands
    // exactly TIMEOUT_CYCLES cycles after the grant edge.
    localparam logic WD_EN  = (TIMEOUT_CYCLES != 0);
    localparam int   TO_LIM = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              grant_id;
    logic              grant;
    logic              grant_sel;
    logic              sel_we;
    logic              aw_done;
    logic              w_done;
    logic              active;
    logic              wd_fire;
    logic [TO_W-1:0]   wd_cnt;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;

    always_comb begin
        grant     = 1'b0;
        grant_sel = 1'b0;
        if (r0_req && r1_req) begin
            grant     = 1'b1;
            grant_sel = ~last_grant;
        end else if (r0_req) begin
            grant     = 1'b1;
        end else if (r1_req) begin
            grant     = 1'b1;
            grant_sel = 1'b1;
        end
    end

    assign sel_we  = grant_sel ? r1_we : r0_we;
    assign active  = (state == WR_ADDR) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);
    assign wd_fire = WD_EN && active && (wd_cnt == TO_W'(TO_LIM));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = sel_we ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (wd_fire) state_nx = DONE;
                     else if ((aw_done || m_awready) && (w_done || m_wready))
                         state_nx = WR_RESP;
            WR_RESP: if (wd_fire || m_bvalid) state_nx = DONE;
            RD_ADDR: if (wd_fire) state_nx = DONE;
                     else if (m_arready) state_nx = RD_DATA;
            RD_DATA: if (wd_fire || m_rvalid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Channel strobes are gated in the watchdog cycle so no late handshake
    // can sneak through while the command is being aborted.
    assign m_awvalid = (state == WR_ADDR) && !aw_done && !wd_fire;
    assign m_wvalid  = (state == WR_ADDR) && !w_done  && !wd_fire;
    assign m_bready  = (state == WR_RESP) && !wd_fire;
    assign m_arvalid = (state == RD_ADDR) && !wd_fire;
    assign m_rready  = (state == RD_DATA) && !wd_fire;
    assign m_awaddr  = cmd_addr;
    assign m_araddr  = cmd_addr;
    assign m_wdata   = cmd_wdata;
    assign m_wstrb   = cmd_wstrb;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;

    assign r0_ack    = (state == DONE) && !grant_id;
    assign r1_ack    = (state == DONE) &&  grant_id;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= '0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_wstrb   <= '0;
            rdata       <= '0;
            resp        <= '0;
            ack_id      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant) begin
                grant_id  <= grant_sel;
                cmd_addr  <= grant_sel ? r1_addr  : r0_addr;
                cmd_wdata <= grant_sel ? r1_wdata : r0_wdata;
                cmd_wstrb <= grant_sel ? r1_wstrb : r0_wstrb;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                wd_cnt    <= '0;
                // Only contention moves the round-robin pointer.
                if (r0_req && r1_req) last_grant <= grant_sel;
            end else if (active && WD_EN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (m_awvalid && m_awready) aw_done <= 1'b1;
            if (m_wvalid && m_wready)   w_done  <= 1'b1;
            if (m_bready && m_bvalid)   resp    <= m_bresp;
            if (m_rready && m_rvalid) begin
                rdata <= m_rdata;
                resp  <= m_rresp;
            end
            if (wd_fire) begin
                resp        <= 2'b10;
                timeout_err <= 1'b1;
            end
            if (state_nx == DONE) ack_id <= grant_id;
        end
    end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Self-checking bench: a behavioural AXI4-Lite slave with programmable stalls,
// per-scenario tasks, and a completion scoreboard keyed on ack pulses.
module tb_axi_lite_req_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    logic        tb_ACLK;
    logic        tb_ARESET;
    logic        r0_req, r0_we, r0_ack;
    logic [31:0] r0_addr, r0_wdata;
    logic [3:0]  r0_wstrb;
    logic        r1_req, r1_we, r1_ack;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        ack_id, busy, timeout_err;
    logic [2:0]  dbg_state;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int checks   = 0;
    int failures = 0;
    logic [34:0] exp_q[$];   // {ack_id, resp, rdata}
    logic [31:0] model_rdata = 32'h0;

    // slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
    bit          hang_b = 0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] mem [4];

    axi_lite_req_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wstrb(r0_wstrb), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wstrb(r1_wstrb), .r1_ack(r1_ack),
        .rdata(rdata), .resp(resp), .ack_id(ack_id), .busy(busy),
        .timeout_err(timeout_err), .dbg_state(dbg_state),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // clock / reset
    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    // Behavioural slave: decisions made on the falling edge hold through the
    // next rising edge, so p_* record exactly what handshook on that edge.
    initial begin
        logic        p_aw, p_w, p_b, p_ar, p_r, got_aw, got_w, b_pend, r_pend;
        logic [31:0] p_awaddr, p_wdata, p_araddr, s_awaddr, s_wdata, s_araddr;
        logic [3:0]  p_wstrb, s_wstrb;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge tb_ACLK);
            if (tb_ARESET) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (p_aw) begin got_aw = 1; s_awaddr = p_awaddr; end
                if (p_w)  begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
                if (p_b)  b_pend = 0;
                if (p_ar) begin r_pend = 1; r_cnt = 0; s_araddr = p_araddr; end
                if (p_r)  r_pend = 0;
                if (got_aw && got_w) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
                end
                if (m_awvalid && !got_aw) begin aw_cnt++; m_awready = (aw_cnt > aw_dly); end
                else begin aw_cnt = 0; m_awready = 0; end
                if (m_wvalid && !got_w) begin w_cnt++; m_wready = (w_cnt > w_dly); end
                else begin w_cnt = 0; m_wready = 0; end
                if (b_pend && !hang_b) begin b_cnt++; m_bvalid = (b_cnt > b_dly); end
                else m_bvalid = 0;
                m_bresp = 2'b00;
                if (m_arvalid && !r_pend) begin ar_cnt++; m_arready = (ar_cnt > 0); end
                else begin ar_cnt = 0; m_arready = 0; end
                if (r_pend) begin
                    r_cnt++;
                    m_rvalid = (r_cnt > r_dly);
                    m_rdata  = mem[s_araddr[3:2]];
                    m_rresp  = rresp_cfg;
                end else m_rvalid = 0;
                p_aw = m_awvalid && m_awready; p_awaddr = m_awaddr;
                p_w  = m_wvalid && m_wready;   p_wdata = m_wdata; p_wstrb = m_wstrb;
                p_b  = m_bvalid && m_bready;
                p_ar = m_arvalid && m_arready; p_araddr = m_araddr;
                p_r  = m_rvalid && m_rready;
            end
        end
    end

    // scoreboard: every ack pulse pops one expected completion
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge tb_ACLK);
            if (!tb_ARESET && (r0_ack || r1_ack)) begin
                checks++;
                if (r0_ack && r1_ack) begin
                    failures++;
                    $display("FAIL dual_ack: r0_ack=%0b r1_ack=%0b, need one-hot", r0_ack, r1_ack);
                end
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: r0_ack=%0b r1_ack=%0b with empty queue", r0_ack, r1_ack);
                end else begin
                    e = exp_q.pop_front();
                    checks += 3;
                    if ({r1_ack, ack_id} !== {e[34], e[34]}) begin
                        failures++;
                        $display("FAIL sb_ack_id: r1_ack=%0b ack_id=%0b expected id %0b", r1_ack, ack_id, e[34]);
                    end
                    if (resp !== e[33:32]) begin
                        failures++;
                        $display("FAIL sb_resp: got %b expected %b", resp, e[33:32]);
                    end
                    if (rdata !== e[31:0]) begin
                        failures++;
                        $display("FAIL sb_rdata: got %h expected %h", rdata, e[31:0]);
                    end
                end
            end
        end
    end

    function automatic cmd_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return '{we: 1'b1, addr: a, wdata: d, wstrb: s};
    endfunction

    function automatic cmd_t rd(input logic [31:0] a);
        return '{we: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0};
    endfunction

    function automatic void expect_cmd(input logic id, input logic we, input logic [1:0] rsp,
                                       input logic [31:0] rd_val);
        if (!we) model_rdata = rd_val;
        exp_q.push_back({id, rsp, model_rdata});
    endfunction

    // driver: raises the enabled requests, drops each on its ack, and reports
    // the ack cycle (1 = first cycle after the sampling edge) and strobe counts
    task automatic drive(input bit gap, input bit en0, input cmd_t c0, input bit en1, input cmd_t c1,
                         output int t0, output int t1, output int n_aw, output int n_w,
                         output int n_rr);
        bit p0, p1;
        int cyc;
        if (gap) @(negedge tb_ACLK);
        if (en0) begin r0_we = c0.we; r0_addr = c0.addr; r0_wdata = c0.wdata; r0_wstrb = c0.wstrb; r0_req = 1; end
        if (en1) begin r1_we = c1.we; r1_addr = c1.addr; r1_wdata = c1.wdata; r1_wstrb = c1.wstrb; r1_req = 1; end
        p0 = en0; p1 = en1; cyc = 0; t0 = -1; t1 = -1; n_aw = 0; n_w = 0; n_rr = 0;
        while ((p0 || p1) && cyc < 100) begin
            @(negedge tb_ACLK);
            cyc++;
            if (m_awvalid) n_aw++;
            if (m_wvalid)  n_w++;
            if (m_rready)  n_rr++;
            if (p0 && r0_ack) begin t0 = cyc; p0 = 0; r0_req = 0; end
            if (p1 && r1_ack) begin t1 = cyc; p1 = 0; r1_req = 0; end
        end
        if (p0 || p1) begin
            checks++; failures++;
            $display("FAIL drive_timeout: pending r0=%0b r1=%0b after %0d cycles", p0, p1, cyc);
            r0_req = 0; r1_req = 0;
        end
    endtask

    task automatic test_reset();
        checks += 3;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, r0_ack, r1_ack, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 00000000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, r0_ack, r1_ack, busy});
        end
        if ({rdata, resp, ack_id, timeout_err} !== 36'h0) begin
            failures++;
            $display("FAIL reset_regs: rdata=%h resp=%b ack_id=%b timeout_err=%b expected zeros",
                     rdata, resp, ack_id, timeout_err);
        end
        if ({m_awprot, m_arprot, dbg_state} !== 9'h0) begin
            failures++;
            $display("FAIL reset_prot_state: awprot=%b arprot=%b state=%0d expected 0",
                     m_awprot, m_arprot, dbg_state);
        end
    endtask

    task automatic test_basic_rw();
        int t0, t1, na, nw, nr;
        expect_cmd(1'b0, 1'b1, 2'b00, 32'h0);
        drive(1, 1, wr(32'h00, 32'h0101FFFF, 4'hF), 0, '0, t0, t1, na, nw, nr);
        checks += 2;
        if (t0 !== 3) begin failures++; $display("FAIL basic_wr_latency: ack cycle %0d expected 3", t0); end
        if (na !== 1 || nw !== 1) begin
            failures++; $display("FAIL basic_wr_valid: aw=%0d w=%0d expected 1/1", na, nw);
        end
        // issued straight after the ack: back-to-back spacing
        expect_cmd(1'b0, 1'b0, 2'b00, 32'h0101FFFF);
        drive(0, 1, rd(32'h00), 0, '0, t0, t1, na, nw, nr);
        checks++;
        if (t0 !== 4) begin failures++; $display("FAIL back_to_back_latency: ack after %0d cycles expected 4", t0); end
    endtask

    task automatic test_contention();
        int t0, t1, na, nw, nr;
        expect_cmd(1'b0, 1'b1, 2'b00, 32'h0);
        expect_cmd(1'b1, 1'b1, 2'b00, 32'h0);
        drive(1, 1, wr(32'h04, 32'habcd0001, 4'hF), 1, wr(32'h08, 32'hdead0011, 4'hF), t0, t1, na, nw, nr);
        checks++;
        if (t0 !== 3 || t1 !== 7) begin
            failures++; $display("FAIL contention_wr_order: r0 at %0d r1 at %0d expected 3/7", t0, t1);
        end
        // r1 won last contention's loser slot, so it goes first now
        expect_cmd(1'b1, 1'b0, 2'b00, 32'habcd0001);
        expect_cmd(1'b0, 1'b0, 2'b00, 32'hdead0011);
        drive(1, 1, rd(32'h08), 1, rd(32'h04), t0, t1, na, nw, nr);
        checks++;
        if (t1 !== 3 || t0 !== 7) begin
            failures++; $display("FAIL contention_rd_order: r1 at %0d r0 at %0d expected 3/7", t1, t0);
        end
    endtask

    task automatic test_wready_stall();
        int t0, t1, na, nw, nr;
        w_dly = 3;
        expect_cmd(1'b0, 1'b1, 2'b00, 32'h0);
        drive(1, 1, wr(32'h0C, 32'hbeef0011, 4'hF), 0, '0, t0, t1, na, nw, nr);
        w_dly = 0;
        checks += 2;
        if (na !== 1 || nw !== 4) begin
            failures++; $display("FAIL stall_valid_len: aw=%0d w=%0d expected 1/4", na, nw);
        end
        if (t0 !== 6) begin failures++; $display("FAIL stall_latency: ack cycle %0d expected 6", t0); end
        expect_cmd(1'b0, 1'b0, 2'b00, 32'hbeef0011);
        drive(1, 1, rd(32'h0C), 0, '0, t0, t1, na, nw, nr);
        expect_cmd(1'b1, 1'b1, 2'b00, 32'h0);
        drive(1, 0, '0, 1, wr(32'h0C, 32'h12345678, 4'b0011), t0, t1, na, nw, nr);
        expect_cmd(1'b1, 1'b0, 2'b00, 32'hbeef5678);
        drive(1, 0, '0, 1, rd(32'h0C), t0, t1, na, nw, nr);
    endtask

    task automatic test_slow_read_err();
        int t0, t1, na, nw, nr;
        r_dly = 5; rresp_cfg = 2'b10;
        expect_cmd(1'b1, 1'b0, 2'b10, 32'h0101FFFF);
        drive(1, 0, '0, 1, rd(32'h00), t0, t1, na, nw, nr);
        r_dly = 0; rresp_cfg = 2'b00;
        checks += 2;
        if (nr !== 6) begin failures++; $display("FAIL slow_rready_len: rready cycles %0d expected 6", nr); end
        if (t1 !== 8) begin failures++; $display("FAIL slow_latency: ack cycle %0d expected 8", t1); end
    endtask

    task automatic test_timeout();
        int t0, t1, na, nw, nr;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++; $display("FAIL timeout_pre: timeout_err=%b expected 0", timeout_err);
        end
        hang_b = 1;
        expect_cmd(1'b0, 1'b1, 2'b10, 32'h0);
        drive(1, 1, wr(32'h04, 32'h5555aaaa, 4'hF), 0, '0, t0, t1, na, nw, nr);
        checks += 2;
        if (t0 !== 16) begin failures++; $display("FAIL timeout_latency: ack cycle %0d expected 16", t0); end
        if (timeout_err !== 1'b1) begin
            failures++; $display("FAIL timeout_set: timeout_err=%b expected 1", timeout_err);
        end
        repeat (5) @(negedge tb_ACLK);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL timeout_sticky: timeout_err=%b busy=%b expected 1/0", timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1, na, nw, nr;
        @(negedge tb_ACLK);
        r_dly = 10;
        r0_we = 0; r0_addr = 32'h00; r0_req = 1;
        for (int i = 0; i < 20 && !m_rready; i++) @(negedge tb_ACLK);
        checks++;
        if (m_rready !== 1'b1) begin failures++; $display("FAIL reset_mid_reach: m_rready=%b expected 1", m_rready); end
        @(negedge tb_ACLK);
        #2 tb_ARESET = 1;
        #1;
        checks += 2;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, r0_ack, r1_ack, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_strobes: got %b expected 00000000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, r0_ack, r1_ack, busy});
        end
        if ({resp, ack_id, timeout_err} !== 4'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_regs: rdata=%h resp=%b ack_id=%b timeout_err=%b expected zeros",
                     rdata, resp, ack_id, timeout_err);
        end
        r0_req = 0;
        model_rdata = 32'h0;
        repeat (2) @(negedge tb_ACLK);
        tb_ARESET = 0; hang_b = 0; r_dly = 0;
        expect_cmd(1'b0, 1'b0, 2'b00, 32'hbeef5678);
        expect_cmd(1'b1, 1'b0, 2'b00, 32'hdead0011);
        drive(1, 1, rd(32'h0C), 1, rd(32'h08), t0, t1, na, nw, nr);
        checks++;
        if (t0 !== 3 || t1 !== 7) begin
            failures++; $display("FAIL reset_rr_restart: r0 at %0d r1 at %0d expected 3/7", t0, t1);
        end
    endtask

    initial begin
        tb_ARESET = 1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_wstrb = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_wstrb = 0;
        repeat (3) @(negedge tb_ACLK);
        test_reset();
        tb_ARESET = 0;
        @(negedge tb_ACLK);
        test_reset();
        test_basic_rw();
        test_contention();
        test_wready_stall();
        test_slow_read_err();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge tb_ACLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover: %0d completions never acked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
